// File: rtl/sram_ctrl_pkg.sv
// Shared widths, FSM encoding and clear bound for the port-0 SRAM controller.
package sram_ctrl_pkg;
  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WMASKS = 4;
  localparam int CLEAR_LAST = 2**ADDR_WIDTH - 1;

  typedef enum logic {ARB, CLEAR} state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  logic last_grant;  // 1 = r1 was granted last

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[0] && req[1]) grant = last_grant ? 2'b01 : 2'b10;
      else                  grant = req;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)          last_grant <= 1'b1;
    else if (|grant)  last_grant <= grant[1];
endmodule

// File: rtl/sram_port0_arbiter.sv
// Shares OpenRAM port 0 between two requesters and adds a bulk zero-fill engine.
// Macro pins are driven combinationally because the macro registers its own inputs.
module sram_port0_arbiter #(
  parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [NUM_WMASKS-1:0] r0_wmask,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [NUM_WMASKS-1:0] r1_wmask,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);
  import sram_ctrl_pkg::*;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  done_nxt;
  logic [1:0]            grant;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state == ARB),
    .req   ({r1_valid, r0_valid}),
    .grant (grant)
  );

  assign r0_ready   = grant[0];
  assign r1_ready   = grant[1];
  assign r0_rdata   = sram_dout0;
  assign r1_rdata   = sram_dout0;
  assign clear_busy = (state == CLEAR);

  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b0;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (state == CLEAR) begin
      sram_csb0   = 1'b0;
      sram_wmask0 = '1;
      sram_addr0  = cnt;
    end else if (grant[0]) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~r0_we;
      sram_wmask0 = r0_wmask;
      sram_addr0  = r0_addr;
      sram_din0   = r0_wdata;
    end else if (grant[1]) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~r1_we;
      sram_wmask0 = r1_wmask;
      sram_addr0  = r1_addr;
      sram_din0   = r1_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      ARB:   if (clear_start) state_nxt = CLEAR;
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        // terminal compare is all ones; no wrap past the top word
        if (cnt == {ADDR_WIDTH{1'b1}}) begin
          state_nxt = ARB;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= ARB;
      cnt        <= '0;
      clear_done <= 1'b0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clear_done <= done_nxt;
      r0_rvalid  <= grant[0] & ~r0_we;
      r1_rvalid  <= grant[1] & ~r1_we;
    end
endmodule
